// File: rtl/trig_burst_scheduler.sv
// Trigger burst scheduler: turns an external, software or free-running trigger into a
// burst of single-cycle pulses with a programmable start delay, period and burst length.
module trig_burst_scheduler #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               EN,
    input  logic [1:0]         Src_sel,
    input  logic               Ext_trig,
    input  logic               Sw_trig,
    input  logic [CNT_W-1:0]   Delay,
    input  logic [CNT_W-1:0]   Period,
    input  logic [BURST_W-1:0] Burst_cnt,
    output logic               Pulse_out,
    output logic               STrig_out,
    output logic               Busy,
    output logic               Done,
    output logic               Missed
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]         r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic [1:0]         r_fill;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_period;
    logic [BURST_W-1:0] r_rem;
    logic               r_pulse;
    logic               r_strig;
    logic               r_done;
    logic               r_missed;

    logic               w_idle;
    logic               w_ext_evt;
    logic               w_trig;
    logic [CNT_W-1:0]   w_period_clamped;
    logic [1:0]         w_next_state;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_period_next;
    logic [BURST_W-1:0] w_rem_next;
    logic               w_done_next;
    logic               w_missed_next;

    assign w_idle = (r_state == S_IDLE);

    // Edges are only honoured once the sync chain holds real samples, so a trigger
    // line already high when reset/enable is released does not fire.
    assign w_ext_evt = r_sync2 & ~r_sync3 & (r_fill == 2'd3);

    assign w_period_clamped = (Period < CNT_W'(2)) ? CNT_W'(2) : Period;

    always_comb begin
        w_trig = 1'b0;
        case (Src_sel)
            2'd0:    w_trig = w_ext_evt;
            2'd1:    w_trig = Sw_trig;
            2'd2:    w_trig = w_ext_evt | Sw_trig;
            default: w_trig = w_idle;
        endcase
    end

    assign w_missed_next = w_trig & ~w_idle & (Src_sel != 2'd3);

    always_comb begin
        w_next_state  = r_state;
        w_cnt_next    = r_cnt;
        w_period_next = r_period;
        w_rem_next    = r_rem;
        w_done_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_period_next = w_period_clamped;
                    w_rem_next    = Burst_cnt;
                    if (Delay == '0) begin
                        w_next_state = S_PULSE;
                        w_cnt_next   = '0;
                    end else begin
                        w_next_state = S_DELAY;
                        w_cnt_next   = Delay;
                    end
                end
            end
            S_DELAY: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_next_state = S_PULSE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_PULSE: begin
                // A remaining count of zero means an endless burst.
                if (r_rem == BURST_W'(1)) begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = '0;
                    w_done_next  = 1'b1;
                end else begin
                    w_next_state = S_GAP;
                    w_cnt_next   = r_period - CNT_W'(2);
                    if (r_rem != '0) begin
                        w_rem_next = r_rem - BURST_W'(1);
                    end
                end
            end
            default: begin
                if (r_cnt == '0) begin
                    w_next_state = S_PULSE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync3  <= 1'b0;
            r_fill   <= 2'd0;
            r_cnt    <= '0;
            r_period <= '0;
            r_rem    <= '0;
            r_pulse  <= 1'b0;
            r_strig  <= 1'b0;
            r_done   <= 1'b0;
            r_missed <= 1'b0;
        end else if (!EN) begin
            r_state  <= S_IDLE;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync3  <= 1'b0;
            r_fill   <= 2'd0;
            r_cnt    <= '0;
            r_period <= '0;
            r_rem    <= '0;
            r_pulse  <= 1'b0;
            r_strig  <= 1'b0;
            r_done   <= 1'b0;
            r_missed <= 1'b0;
        end else begin
            r_sync1  <= Ext_trig;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            if (r_fill != 2'd3) begin
                r_fill <= r_fill + 2'd1;
            end
            r_state  <= w_next_state;
            r_cnt    <= w_cnt_next;
            r_period <= w_period_next;
            r_rem    <= w_rem_next;
            r_pulse  <= (w_next_state == S_PULSE);
            if (w_next_state == S_PULSE) begin
                r_strig <= ~r_strig;
            end
            r_done   <= w_done_next;
            r_missed <= w_missed_next;
        end
    end

    assign Pulse_out = r_pulse;
    assign STrig_out = r_strig;
    assign Busy      = ~w_idle;
    assign Done      = r_done;
    assign Missed    = r_missed;

endmodule

// File: doc/trig_burst_scheduler.md
TRIG_BURST_SCHEDULER -- requirements
Module: trig_burst_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the Delay, Period and internal timer counters.
REQ-002 SHALL have parameter BURST_W, default 8, width of the Burst_cnt input and the remaining-pulse counter.
REQ-003 SHALL have port Clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port EN  input  1  block enable; low means synchronous abort and hold in idle.
REQ-006 SHALL have port Src_sel  input  2  trigger source: 0 external, 1 software, 2 external OR software, 3 internal free-run.
REQ-007 SHALL have port Ext_trig  input  1  asynchronous external trigger level.
REQ-008 SHALL have port Sw_trig  input  1  synchronous single-cycle software trigger strobe.
REQ-009 SHALL have port Delay  input  CNT_W  cycles from accepted trigger to first pulse.
REQ-010 SHALL have port Period  input  CNT_W  cycles between successive pulse starts.
REQ-011 SHALL have port Burst_cnt  input  BURST_W  pulses per burst; 0 means infinite.
REQ-012 SHALL have port Pulse_out  output  1  one-cycle trigger pulse per burst element.
REQ-013 SHALL have port STrig_out  output  1  level that toggles on every Pulse_out.
REQ-014 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port Done  output  1  one-cycle strobe when a finite burst completes.
REQ-016 SHALL have port Missed  output  1  one-cycle strobe when a trigger event arrives while Busy.

Function
REQ-017 SHALL synchronise Ext_trig through two flops plus a third history flop; ext event = sync2 & ~sync3 (rising edge only).
REQ-018 SHALL form the trigger event per Src_sel; for Src_sel=3 the event is asserted every cycle the FSM is in IDLE with EN high.
REQ-019 SHALL implement FSM states IDLE, DELAY, PULSE, GAP, all registered.
REQ-020 SHALL, on an event in IDLE, latch Delay, Period and Burst_cnt; all later changes to these inputs are ignored until the next IDLE.
REQ-021 SHALL go IDLE->PULSE if latched Delay=0, else IDLE->DELAY and load the counter with Delay.
REQ-022 SHALL decrement in DELAY and go to PULSE when the counter is 1, so the first Pulse_out is high in cycle k+1+Delay for an event at edge k.
REQ-023 SHALL drive Pulse_out=1 (registered) only in PULSE, and toggle STrig_out on the same edge Pulse_out rises.
REQ-024 SHALL, leaving PULSE, decrement remaining pulses (unless infinite); if none remain go IDLE with Done=1 for one cycle, else go GAP with counter=Period-2.
REQ-025 SHALL clamp latched Period values 0 and 1 to 2, so pulse starts are exactly max(Period,2) cycles apart.
REQ-026 SHALL go GAP->PULSE when the GAP counter reaches 0 (including immediately when it was loaded with 0).
REQ-027 SHALL, on any event while Busy (Src_sel 0-2), ignore it and pulse Missed for one cycle; Src_sel=3 never sets Missed.
REQ-028 SHALL, when EN is low at a rising edge, force IDLE and clear the sync flops, counters, Pulse_out, STrig_out, Done and Missed to 0 regardless of state.
REQ-029 SHALL never assert Done for an infinite burst or for an EN abort.
REQ-030 SHALL use wrap-free counters: the remaining-pulse counter never decrements below 1 in finite mode.

Reset
REQ-031 SHALL, while Reset_n=0, asynchronously set the FSM to IDLE and all outputs, counters and sync flops to 0.
REQ-032 SHALL resume normal operation on the first rising Clock edge after Reset_n deasserts, with no spurious event from Ext_trig already high.

Verification
REQ-033 Src_sel=1, Delay=3, Period=5, Burst_cnt=3, Sw_trig at edge 10 -> Pulse_out at cycles 14,19,24; STrig_out 0->1->0->1; Done at cycle 25; Busy 11..24.
REQ-034 Src_sel=0, Delay=0, Burst_cnt=1, Ext_trig rises between edges 20 and 21 -> event at edge 23, Pulse_out at cycle 24, Done at 25.
REQ-035 Src_sel=1, burst running, Sw_trig mid-burst -> Missed=1 for one cycle, pulse timing unchanged; Delay changed mid-burst has no effect.
REQ-036 Src_sel=3, Delay=0, Period=1, Burst_cnt=2 -> pulses every 2 cycles within a burst, new burst restarts one cycle after Done, no Missed.
REQ-037 Burst_cnt=0, Period=4, EN dropped after 5 pulses -> next edge IDLE, STrig_out=0, no Done; EN re-raised accepts next trigger normally.
REQ-038 Reset_n asserted during DELAY with Ext_trig held high -> outputs 0 immediately; after release, no event until Ext_trig falls and rises again.
